// File: rtl/nn_pkg.sv
// nn_pkg -- constants and types shared by the PE-array blocks.
//   NUM_IN : activations per packed vector (PE `in` bus lane count)
//   ACT_W  : activation width, sign-magnitude, MSB is the sign
//   VEC_W  : packed vector width, NUM_IN*ACT_W
//   CNT_W  : width of the slot fill counter
//   state_e: act_packer FSM states
package nn_pkg;
  localparam int NUM_IN = 62;
  localparam int ACT_W  = 8;
  localparam int VEC_W  = NUM_IN * ACT_W;
  localparam int CNT_W  = 6;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;
endpackage

// File: rtl/act_packer_if.sv
// act_packer_if -- stream-in / vector-out bus of the activation packer.
// Handshake: a word moves across a channel on a rising clk edge where
// valid and ready are both high; valid never waits on ready.
//   in_valid/in_data/in_ready : producer -> packer, one activation per beat
//   flush                     : producer asks to close a partial vector
//   out_valid/out_vec/out_ready : packer -> consumer, one packed vector
//   fill_cnt                  : slots filled in the current vector
// Modports: master = producer + consumer side, slave = the packer.
interface act_packer_if #(
  parameter int NUM_IN = nn_pkg::NUM_IN,
  parameter int ACT_W  = nn_pkg::ACT_W
);
  logic                    in_valid;
  logic [ACT_W-1:0]        in_data;
  logic                    in_ready;
  logic                    flush;
  logic                    out_valid;
  logic [NUM_IN*ACT_W-1:0] out_vec;
  logic                    out_ready;
  logic [nn_pkg::CNT_W-1:0] fill_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_vec, fill_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_vec, fill_cnt
  );
endinterface

// File: rtl/act_packer.sv
// act_packer -- gathers single activations into one NUM_IN-slot vector.
// Slot k (bits [k*ACT_W +: ACT_W]) holds the k-th accepted activation.
// The vector closes when all slots are filled or on flush (unfilled slots
// stay zero), is then held until the consumer takes it, and the next vector
// starts one cycle after that handoff.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : act_packer_if.slave (input stream, flush, output vector, fill_cnt)
//   state_o  : current FSM state, for debug/observation
//   neg_err  : only with ACT_PACKER_NEG_CLAMP_EN -- sticky flag, set when a
//              negative activation was accepted (and stored as zero)
// Build option: ACT_PACKER_NEG_CLAMP_EN clamps negative inputs to zero.
module act_packer
  import nn_pkg::state_e, nn_pkg::FILL, nn_pkg::FULL, nn_pkg::CNT_W;
#(
  parameter int NUM_IN = nn_pkg::NUM_IN,
  parameter int ACT_W  = nn_pkg::ACT_W
) (
  input  logic        clk,
  input  logic        rst,
  act_packer_if.slave bus,
  output state_e      state_o
`ifdef ACT_PACKER_NEG_CLAMP_EN
  ,
  output logic        neg_err
`endif
);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_IN*ACT_W-1:0] vec_q;
  logic                    accept;
  logic                    last_slot;
  logic [ACT_W-1:0]        wr_data;

`ifdef ACT_PACKER_NEG_CLAMP_EN
  logic neg_err_q;
  assign wr_data = bus.in_data[ACT_W-1] ? '0 : bus.in_data;
  assign neg_err = neg_err_q;
`else
  assign wr_data = bus.in_data;
`endif

  // The handshake outputs are masked by rst so nothing moves while reset
  // is held, even in the cycle before the synchronous reset takes effect.
  assign bus.in_ready  = (state_q == FILL) && !rst;
  assign bus.out_valid = (state_q == FULL) && !rst;
  assign bus.out_vec   = vec_q;
  assign bus.fill_cnt  = cnt_q;
  assign state_o       = state_q;

  assign accept    = bus.in_ready && bus.in_valid;
  assign last_slot = (cnt_q == CNT_W'(NUM_IN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      vec_q   <= '0;
`ifdef ACT_PACKER_NEG_CLAMP_EN
      neg_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            for (int i = 0; i < NUM_IN; i++) begin
              if (cnt_q == CNT_W'(i)) vec_q[i*ACT_W +: ACT_W] <= wr_data;
            end
            cnt_q <= cnt_q + 1'b1;
            // A flush in the same beat closes the vector after this byte.
            if (last_slot || bus.flush) state_q <= FULL;
`ifdef ACT_PACKER_NEG_CLAMP_EN
            if (bus.in_data[ACT_W-1]) neg_err_q <= 1'b1;
`endif
          end else if (bus.flush && (cnt_q != '0)) begin
            state_q <= FULL;
          end
        end
        FULL: begin
          // Clearing here keeps unfilled slots of the next vector at zero.
          if (bus.out_ready) begin
            state_q <= FILL;
            cnt_q   <= '0;
            vec_q   <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_act_packer.sv
// tb_act_packer -- randomized and directed stimulus for act_packer, checked
// each cycle against a queue-based model of the packing rules.
module tb_act_packer;
  import nn_pkg::*;

  logic   clk;
  logic   rst;
  state_e state;
`ifdef ACT_PACKER_NEG_CLAMP_EN
  logic   neg_err;
`endif

  act_packer_if bus ();

  act_packer dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
`ifdef ACT_PACKER_NEG_CLAMP_EN
    ,
    .neg_err (neg_err)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [ACT_W-1:0] exp_q[$];  // bytes of the vector being built / held
  bit               m_full;    // model: vector closed and waiting
  bit               m_neg;     // model: sticky negative flag

  task automatic check(input string tag, input logic [VEC_W-1:0] obs,
                       input logic [VEC_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] model_vec();
    logic [VEC_W-1:0] v = '0;
    foreach (exp_q[i]) v[i*ACT_W +: ACT_W] = exp_q[i];
    return v;
  endfunction

  // One clock: drive inputs, compare outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic iv, input logic [ACT_W-1:0] d,
                      input logic fl, input logic ordy);
    rst          = r;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.flush    = fl;
    bus.out_ready = ordy;
    @(negedge clk);
    check("in_ready",  {495'b0, bus.in_ready},  {495'b0, (!r && !m_full)});
    check("out_valid", {495'b0, bus.out_valid}, {495'b0, (!r && m_full)});
    check("fill_cnt",  VEC_W'(bus.fill_cnt), VEC_W'(exp_q.size()));
    check("out_vec",   bus.out_vec, model_vec());
`ifdef ACT_PACKER_NEG_CLAMP_EN
    check("neg_err",   {495'b0, neg_err}, {495'b0, m_neg});
`endif
    if (r) begin
      exp_q.delete();
      m_full = 0;
      m_neg  = 0;
    end else if (!m_full) begin
      if (iv) begin
`ifdef ACT_PACKER_NEG_CLAMP_EN
        if (d[ACT_W-1]) begin
          exp_q.push_back('0);
          m_neg = 1;
        end else exp_q.push_back(d);
`else
        exp_q.push_back(d);
`endif
        if (exp_q.size() == NUM_IN || fl) m_full = 1;
      end else if (fl && exp_q.size() > 0) begin
        m_full = 1;
      end
    end else if (ordy) begin
      exp_q.delete();
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    check("rst_fill_cnt", VEC_W'(bus.fill_cnt), '0);
    check("rst_out_vec",  bus.out_vec, '0);
  endtask

  logic [VEC_W-1:0] vexp;

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.flush = 0; bus.out_ready = 0;
    m_full = 0; m_neg = 0;
    @(posedge clk); #1;
    do_reset();

    // Full vector of bytes 1..62, held while out_ready stays low.
    for (int i = 1; i <= NUM_IN; i++) step(0, 1, ACT_W'(i), 0, 0);
    check("full_valid", {495'b0, bus.out_valid}, {495'b0, 1'b1});
    check("full_byte0", VEC_W'(bus.out_vec[7:0]), VEC_W'(8'h01));
    check("full_top",   VEC_W'(bus.out_vec[495:488]), VEC_W'(8'h3E));
    for (int i = 0; i < 10; i++) step(0, 1, 8'hAA, 0, 0);
    check("held_cnt", VEC_W'(bus.fill_cnt), VEC_W'(NUM_IN));

    // Handoff with in_valid high, then 8'h55 lands in slot 0.
    step(0, 1, 8'h55, 0, 1);
    check("handoff_cnt", VEC_W'(bus.fill_cnt), '0);
    step(0, 1, 8'h55, 0, 0);
    check("refill_cnt",  VEC_W'(bus.fill_cnt), VEC_W'(1));
    check("refill_byte", VEC_W'(bus.out_vec[7:0]), VEC_W'(8'h55));

    // Five 8'h7F then a lone flush.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 8'h7F, 0, 0);
    step(0, 0, '0, 1, 0);
    vexp = '0;
    for (int i = 0; i < 5; i++) vexp[i*8 +: 8] = 8'h7F;
    check("flush_valid", {495'b0, bus.out_valid}, {495'b0, 1'b1});
    check("flush_cnt", VEC_W'(bus.fill_cnt), VEC_W'(5));
    check("flush_vec", bus.out_vec, vexp);
    step(0, 0, '0, 0, 1);

    // Flush together with a byte at fill_cnt=3.
    for (int i = 0; i < 3; i++) step(0, 1, 8'h11, 0, 0);
    step(0, 1, 8'h22, 1, 0);
    check("flushdata_cnt",  VEC_W'(bus.fill_cnt), VEC_W'(4));
    check("flushdata_slot", VEC_W'(bus.out_vec[31:24]), VEC_W'(8'h22));
    step(0, 0, '0, 0, 1);

    // Flush on empty is ignored; reset mid-fill discards.
    step(0, 0, '0, 1, 0);
    check("empty_flush", {495'b0, bus.out_valid}, '0);
    for (int i = 0; i < 30; i++) step(0, 1, ACT_W'($urandom_range(0, 127)), 0, 0);
    check("pre_rst_cnt", VEC_W'(bus.fill_cnt), VEC_W'(30));
    step(1, 0, '0, 0, 0);
    check("mid_rst_cnt",   VEC_W'(bus.fill_cnt), '0);
    check("mid_rst_valid", {495'b0, bus.out_valid}, '0);
    step(0, 0, '0, 0, 0);

`ifdef ACT_PACKER_NEG_CLAMP_EN
    step(0, 1, 8'h85, 1, 0);
    check("clamp_byte", VEC_W'(bus.out_vec[7:0]), '0);
    check("clamp_err",  {495'b0, neg_err}, {495'b0, 1'b1});
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    check("clamp_sticky", {495'b0, neg_err}, {495'b0, 1'b1});
`endif

    // Randomized traffic, including negative bytes and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           ACT_W'($urandom_range(0, 255)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
